// File: rtl/blackhole_pkg.sv
// blackhole_pkg: shared scene states, animation defaults and screen geometry for the black hole renderer.
package blackhole_pkg;
    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        FALL   = 2'd1,
        ABSORB = 2'd2
    } scene_state_t;
    localparam int DEF_TEXT_Y_TOP    = 20;
    localparam int DEF_TEXT_Y_END    = 276;
    localparam int DEF_WAIT_FRAMES   = 256;
    localparam int DEF_ABSORB_FRAMES = 32;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int CENTER_X = 320;
    localparam int CENTER_Y = 240;
endpackage

// File: rtl/frame_edge_detect.sv
// frame_edge_detect: registered one-cycle pulse on each falling edge of the active-low vsync.
module frame_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic frame_tick
);
    logic vsync_prev;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_prev <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vsync_prev <= vsync;
            frame_tick <= !vsync && vsync_prev;
        end
    end
endmodule

// File: rtl/scene_sequencer.sv
// scene_sequencer: frame-rate "UW" text life cycle (wait, fall, absorb) and ring phase,
// with pause, single-step and speed control; outputs only change on the edge ending frame_tick.
module scene_sequencer
    import blackhole_pkg::*;
#(
    parameter int TEXT_Y_TOP    = DEF_TEXT_Y_TOP,
    parameter int TEXT_Y_END    = DEF_TEXT_Y_END,
    parameter int WAIT_FRAMES   = DEF_WAIT_FRAMES,
    parameter int ABSORB_FRAMES = DEF_ABSORB_FRAMES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        pause,
    input  logic        step,
    input  logic [1:0]  speed,
    output logic        frame_tick,
    output logic [15:0] frame_cnt,
    output logic [7:0]  ring_phase,
    output logic [9:0]  text_y,
    output logic        text_visible,
    output logic [1:0]  scene_state
);
    localparam logic [9:0]  Y_TOP       = 10'(TEXT_Y_TOP);
    localparam logic [10:0] Y_END       = 11'(TEXT_Y_END);
    localparam logic [7:0]  WAIT_LAST   = 8'(WAIT_FRAMES - 1);
    localparam logic [7:0]  ABSORB_LAST = 8'(ABSORB_FRAMES - 1);

    scene_state_t state;
    logic        step_pending;
    logic        advance;
    logic [7:0]  timer;
    logic [2:0]  fstep;
    logic [10:0] y_next;

    frame_edge_detect u_edge (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

    assign advance     = frame_tick && (!pause || step_pending || step);
    assign fstep       = {1'b0, speed} + 3'd1;
    // 11-bit sum so the end-row test cannot wrap
    assign y_next      = {1'b0, text_y} + {8'd0, fstep};
    assign scene_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt    <= 16'd0;
            ring_phase   <= 8'd0;
            text_y       <= Y_TOP;
            text_visible <= 1'b1;
            state        <= WAIT;
            timer        <= 8'd0;
            step_pending <= 1'b0;
        end else begin
            if (frame_tick) frame_cnt <= frame_cnt + 16'd1;
            // a step only latches while paused and is consumed by the next advance
            step_pending <= pause && !advance && (step_pending || step);
            if (advance) begin
                ring_phase <= ring_phase + (8'd1 << speed);
                case (state)
                    WAIT: begin
                        timer <= (timer == WAIT_LAST) ? 8'd0 : timer + 8'd1;
                        state <= (timer == WAIT_LAST) ? FALL : WAIT;
                    end
                    FALL: begin
                        if (y_next >= Y_END) begin
                            text_y       <= Y_END[9:0];
                            text_visible <= 1'b0;
                            state        <= ABSORB;
                            timer        <= 8'd0;
                        end else begin
                            text_y <= y_next[9:0];
                        end
                    end
                    ABSORB: begin
                        if (timer == ABSORB_LAST) begin
                            text_y       <= Y_TOP;
                            text_visible <= 1'b1;
                            state        <= WAIT;
                            timer        <= 8'd0;
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end
                    default: begin
                        text_y       <= Y_TOP;
                        text_visible <= 1'b1;
                        state        <= WAIT;
                        timer        <= 8'd0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_scene_sequencer.sv
// tb_scene_sequencer: directed vector table plus hand-written sequences for scene_sequencer.
module tb_scene_sequencer;
    logic        clk = 1'b0;
    logic        reset, vsync, pause, step;
    logic [1:0]  speed;
    logic        frame_tick;
    logic [15:0] frame_cnt;
    logic [7:0]  ring_phase;
    logic [9:0]  text_y;
    logic        text_visible;
    logic [1:0]  scene_state;

    int errors = 0;
    int checks = 0;

    scene_sequencer #(.WAIT_FRAMES(4), .ABSORB_FRAMES(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .vsync        (vsync),
        .pause        (pause),
        .step         (step),
        .speed        (speed),
        .frame_tick   (frame_tick),
        .frame_cnt    (frame_cnt),
        .ring_phase   (ring_phase),
        .text_y       (text_y),
        .text_visible (text_visible),
        .scene_state  (scene_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       p;
        logic [1:0] s;
        int         sm;
        int         fc, rp, ty, st, vis;
    } vec_t;

    vec_t v[22];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int fc, input int rp, input int ty, input int st, input int vis);
        chk({tag, " frame_cnt"}, int'(frame_cnt), fc);
        chk({tag, " ring_phase"}, int'(ring_phase), rp);
        chk({tag, " text_y"}, int'(text_y), ty);
        chk({tag, " state"}, int'(scene_state), st);
        chk({tag, " visible"}, int'(text_visible), vis);
    endtask

    // sm: 0 no step, 1 step coincident with tick, 2 one step mid-frame, 3 two steps mid-frame
    task automatic frame(input logic p, input logic [1:0] s, input int sm);
        int n;
        logic first;
        first = 1'b0;
        pause = p;
        speed = s;
        @(negedge clk);
        vsync = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (frame_tick) n++;
            if (i == 0) first = frame_tick;
            if (i == 2) vsync = 1'b1;
            step = (sm == 1 && i == 0) || (sm == 2 && i == 4) || (sm == 3 && (i == 3 || i == 5));
        end
        step = 1'b0;
        chk("tick shape", {30'd0, first, n == 1}, 3);
    endtask

    initial begin
        v[0]  = '{1'b0, 2'd0, 0,  1,  1, 20, 0, 1};
        v[1]  = '{1'b0, 2'd0, 0,  2,  2, 20, 0, 1};
        v[2]  = '{1'b0, 2'd0, 0,  3,  3, 20, 0, 1};
        v[3]  = '{1'b0, 2'd3, 0,  4, 11, 20, 1, 1};
        v[4]  = '{1'b0, 2'd3, 0,  5, 19, 24, 1, 1};
        v[5]  = '{1'b0, 2'd3, 0,  6, 27, 28, 1, 1};
        v[6]  = '{1'b1, 2'd3, 0,  7, 27, 28, 1, 1};
        v[7]  = '{1'b1, 2'd3, 0,  8, 27, 28, 1, 1};
        v[8]  = '{1'b1, 2'd3, 0,  9, 27, 28, 1, 1};
        v[9]  = '{1'b1, 2'd3, 0, 10, 27, 28, 1, 1};
        v[10] = '{1'b1, 2'd3, 0, 11, 27, 28, 1, 1};
        v[11] = '{1'b1, 2'd0, 2, 12, 27, 28, 1, 1};
        v[12] = '{1'b1, 2'd0, 0, 13, 28, 29, 1, 1};
        v[13] = '{1'b1, 2'd0, 0, 14, 28, 29, 1, 1};
        v[14] = '{1'b1, 2'd1, 1, 15, 30, 31, 1, 1};
        v[15] = '{1'b1, 2'd1, 0, 16, 30, 31, 1, 1};
        v[16] = '{1'b1, 2'd1, 3, 17, 30, 31, 1, 1};
        v[17] = '{1'b1, 2'd1, 0, 18, 32, 33, 1, 1};
        v[18] = '{1'b1, 2'd1, 0, 19, 32, 33, 1, 1};
        v[19] = '{1'b0, 2'd0, 2, 20, 33, 34, 1, 1};
        v[20] = '{1'b1, 2'd0, 0, 21, 33, 34, 1, 1};
        v[21] = '{1'b0, 2'd0, 0, 22, 34, 35, 1, 1};

        reset = 1'b1;
        vsync = 1'b1;
        pause = 1'b0;
        step  = 1'b0;
        speed = 2'd0;
        repeat (3) @(negedge clk);
        chk("reset tick", int'(frame_tick), 0);
        chk_out("reset", 0, 0, 20, 0, 1);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 22; i++) begin
            frame(v[i].p, v[i].s, v[i].sm);
            chk_out($sformatf("vec%0d", i), v[i].fc, v[i].rp, v[i].ty, v[i].st, v[i].vis);
        end

        // fall to 274, land exactly on the end row, then absorb and return to WAIT
        for (int i = 0; i < 59; i++) begin
            frame(1'b0, 2'd3, 0);
            chk($sformatf("fall%0d text_y", i), int'(text_y), 35 + 4 * (i + 1));
        end
        frame(1'b0, 2'd2, 0);
        chk_out("pre-end", 82, 254, 274, 1, 1);
        frame(1'b0, 2'd1, 0);
        chk_out("land", 83, 0, 276, 2, 0);
        frame(1'b0, 2'd0, 0);
        frame(1'b0, 2'd0, 0);
        chk_out("absorb", 85, 2, 276, 2, 0);
        frame(1'b0, 2'd0, 0);
        chk_out("rewait", 86, 3, 20, 0, 1);

        // async reset in the middle of FALL at text_y=150
        repeat (4) frame(1'b0, 2'd0, 0);
        chk_out("refall", 90, 7, 20, 1, 1);
        repeat (32) frame(1'b0, 2'd3, 0);
        frame(1'b0, 2'd1, 0);
        chk_out("mid-fall", 123, 9, 150, 1, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async tick", int'(frame_tick), 0);
        chk_out("async", 0, 0, 20, 0, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        frame(1'b0, 2'd0, 0);
        chk_out("resume", 1, 1, 20, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
